pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Observes the ID stage, the ID/EX register and the EX/MEM register, and drives write-enables and flushes for PC, IF/ID, ID/EX and EX/MEM plus the MEM/WB bubble. Resolves load-use stalls, taken-branch squashes (branch resolved in MEM) and multi-cycle data-memory waits with a timeout. Keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 64: max consecutive wait cycles before an access is abandoned (≥2)
- CNT_W, 16: performance counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- idex_MemRead  in  1  instruction in EX is a load
- idex_rt  in  5  load destination in EX
- exmem_branch  in  1  EX/MEM holds a branch
- exmem_zero  in  1  EX/MEM zero flag
- exmem_MemRead, exmem_MemWrite  in  1 each  EX/MEM memory access
- mem_ready  in  1  data memory completes access this cycle
- mem_req  out  1  = exmem_MemRead | exmem_MemWrite
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (zero controls) into register
- memwb_bubble  out  1  MEM/WB captures zero controls
- pc_src  out  1  select branch target
- mem_err  out  1  sticky timeout flag
- stall_count  out  CNT_W  cycles with pc_write=0, saturating
- flush_count  out  CNT_W  taken branches, saturating

## Operation
- States: RUN, MEM_WAIT. Control outputs are Mealy (combinational from state + inputs); state, wait counter, mem_err and counters are registered.
- Default (no hazard): all *_write=1, all flushes/bubble/pc_src=0.
- Priority per cycle: memory wait > taken branch > load-use.
- Memory wait: mem_req=1 & mem_ready=0 (in RUN or MEM_WAIT) → pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, branch/load-use actions suppressed. RUN→MEM_WAIT, wait_cnt←1.
- In MEM_WAIT: mem_ready=0 → hold freeze, wait_cnt+1; when wait_cnt reaches MEM_TIMEOUT-1 with mem_ready=0, that cycle releases as if ready, mem_err←1, →RUN. mem_ready=1 → release this cycle, →RUN, wait_cnt←0.
- Release cycle: normal branch/load-use decode applies in the same cycle.
- Taken branch: exmem_branch & exmem_zero (not frozen) → pc_src=1, ifid_flush=idex_flush=exmem_flush=1, all writes=1; flush_count+1. Load-use ignored this cycle.
- Load-use: idex_MemRead & idex_rt≠0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)) → pc_write=ifid_write=0, idex_flush=1; exmem_write=1.
- stall_count +1 every cycle pc_write=0 (wait or load-use); both counters saturate at all-ones.
- mem_err clears only on reset.

## Timing
- Reset (async assert, state cleared immediately): state RUN, wait_cnt 0, mem_err 0, counters 0. During reset outputs follow default RUN decode of inputs (mem_req still = input OR).
- Load-use: exactly 1 stall cycle per hazard (bubble advances, hazard clears).
- Taken branch: 3 squashed slots, 1 cycle, no stall.
- Memory access with ready after N cycles (N≥1 including request cycle): N-1 frozen cycles; ready on first cycle → zero stall.
- Timeout: freeze lasts exactly MEM_TIMEOUT-1 cycles after the request cycle, release in the next.
- Reset mid-MEM_WAIT: immediate RUN, counters lost.

## Test plan
- Load-use: idex_MemRead=1, idex_rt=8, id_rs=8 → one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_count=1; idex_rt=0 same stimulus → no stall.
- Taken branch with load-use present: exmem_branch=1, exmem_zero=1 → pc_src=1, three flushes, no stall, flush_count=1; zero=0 → no action.
- Memory wait: exmem_MemRead=1, mem_ready low 3 cycles then high → 3 frozen cycles with memwb_bubble=1, release on 4th, stall_count=3, state back to RUN.
- Wait + branch: exmem_MemWrite=1, exmem_branch=1, zero=1, mem_ready=0 → freeze, pc_src=0; on mem_ready=1 pc_src=1 with flushes.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 → 3 frozen cycles after request, release, mem_err=1 sticky until rst_n=0.
- Saturation/reset: CNT_W=4, 20 stall cycles → stall_count=15; async rst_n pulse mid-wait → all counters 0, state RUN without a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the 5-stage MIPS datapath and its hazard controller.
// The master side is the pipeline and the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             idex_MemRead;
    logic [4:0]       idex_rt;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             exmem_MemRead;
    logic             exmem_MemWrite;
    logic             mem_ready;

    logic             mem_req;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             pc_src;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_MemRead, idex_rt,
               exmem_branch, exmem_zero, exmem_MemRead, exmem_MemWrite, mem_ready,
        input  mem_req, pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src,
               mem_err, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_MemRead, idex_rt,
               exmem_branch, exmem_zero, exmem_MemRead, exmem_MemWrite, mem_ready,
        output mem_req, pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src,
               mem_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, taken-branch
// squashes and data-memory waits with a timeout, plus saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic mem_req;
    logic mem_pending;
    logic at_limit;
    logic freeze;
    logic timeout;
    logic taken;
    logic load_use;
    logic rs_match;
    logic rt_match;

    assign mem_req     = hz.exmem_MemRead | hz.exmem_MemWrite;
    assign mem_pending = mem_req & ~hz.mem_ready;

    // An access that has been frozen MEM_TIMEOUT-1 cycles is released as if ready.
    assign at_limit = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign freeze   = mem_pending & ~at_limit;
    assign timeout  = mem_pending & at_limit;

    assign rs_match = (hz.idex_rt == hz.id_rs);
    assign rt_match = hz.id_uses_rt & (hz.idex_rt == hz.id_rt);
    assign taken    = ~freeze & hz.exmem_branch & hz.exmem_zero;
    assign load_use = ~freeze & ~taken & hz.idex_MemRead & (hz.idex_rt != 5'd0)
                      & (rs_match | rt_match);

    assign hz.mem_req      = mem_req;
    assign hz.pc_write     = ~(freeze | load_use);
    assign hz.ifid_write   = ~(freeze | load_use);
    assign hz.idex_write   = ~freeze;
    assign hz.exmem_write  = ~freeze;
    assign hz.ifid_flush   = taken;
    assign hz.idex_flush   = taken | load_use;
    assign hz.exmem_flush  = taken;
    assign hz.memwb_bubble = freeze;
    assign hz.pc_src       = taken;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_count  = stall_q;
    assign hz.flush_count  = flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (freeze) begin
                state    <= MEM_WAIT;
                wait_cnt <= (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
            if ((freeze | load_use) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (taken && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end
endmodule
